// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer and its return-address stack.
package pc_pkg;

   typedef enum logic [2:0] {
      NEXT = 3'd0,
      JUMP = 3'd1,
      BRZ  = 3'd2,
      BRNZ = 3'd3,
      CALL = 3'd4,
      RET  = 3'd5
   } pc_op_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      FAULT  = 2'd2
   } pc_state_t;

   // Index width for a stack of the given depth; a single-entry stack still needs one bit.
   function automatic int rasIdxWidth(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack (LIFO) used by CALL/RET. Only the occupancy count is reset;
// entry contents are meaningless once popped or cleared.
module pc_ras
   import pc_pkg::*;
#(
   parameter int PW    = 10,
   parameter int DEPTH = 4
)(
   input  logic                         CLK,
   input  logic                         Init_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         clear,
   input  logic [PW-1:0]                din,
   output logic [PW-1:0]                dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = rasIdxWidth(DEPTH);
   localparam int MW = 1 << IW;

   logic [PW-1:0] r_mem [MW];
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_countDec;
   logic [IW-1:0] w_wrIdx;
   logic [IW-1:0] w_rdIdx;

   assign w_countDec = r_count - CW'(1);
   assign w_wrIdx    = r_count[IW-1:0];
   assign w_rdIdx    = w_countDec[IW-1:0];

   // Occupancy counter: clear wins, then push, then pop; saturating guards keep it in range.
   always_ff @(posedge CLK or negedge Init_n) begin
      if (!Init_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (push && !full) begin
         r_count <= r_count + CW'(1);
      end else if (pop && !empty) begin
         r_count <= w_countDec;
      end
   end

   // Entry storage: write the next free slot on a legal push.
   always_ff @(posedge CLK) begin
      if (!clear && push && !full) begin
         r_mem[w_wrIdx] <= din;
      end
   end

   assign full  = (r_count == CW'(DEPTH));
   assign empty = (r_count == '0);
   assign dout  = r_mem[w_rdIdx];
   assign count = r_count;

endmodule

// File: rtl/pc_seq.sv
// Fetch-stage program counter: increment, jump, zero-flag branches, call/return,
// end-of-program detection and sticky stack-fault reporting.
module pc_seq
   import pc_pkg::*;
#(
   parameter int PW         = 10,
   parameter int DEPTH      = 4,
   parameter int START_ADDR = 0,
   parameter int HALT_ADDR  = 63
)(
   input  logic                         CLK,
   input  logic                         Init_n,
   input  logic                         Start,
   input  logic                         Halt,
   input  logic [2:0]                   Op,
   input  logic                         ALU_zero,
   input  logic [PW-1:0]                Target,
   input  logic [PW-1:0]                Offset,
   output logic [PW-1:0]                PC,
   output logic                         Done,
   output logic                         Fault,
   output logic                         Overflow,
   output logic                         Underflow,
   output logic [$clog2(DEPTH+1)-1:0]   Depth
);

   localparam logic [PW-1:0] LP_START = PW'(START_ADDR);
   localparam logic [PW-1:0] LP_HALT  = PW'(HALT_ADDR);

   logic [PW-1:0] r_pc;
   pc_state_t     r_state;
   logic          r_overflow;
   logic          r_underflow;

   pc_op_t        w_op;
   logic          w_active;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [PW-1:0] w_rasTop;
   logic [PW-1:0] w_pcInc;
   logic [PW-1:0] w_pcRel;
   logic [PW-1:0] w_nextPc;

   assign w_op    = pc_op_t'(Op);
   assign w_pcInc = r_pc + PW'(1);
   assign w_pcRel = r_pc + Offset;

   // An op only takes effect when running, not stalled or restarting, and not at the halt address.
   assign w_active = !Start && !Halt && (r_state == RUN) && (r_pc != LP_HALT);
   assign w_push   = w_active && (w_op == CALL) && !w_full;
   assign w_pop    = w_active && (w_op == RET) && !w_empty;

   pc_ras #(
      .PW    (PW),
      .DEPTH (DEPTH)
   ) u_ras (
      .CLK    (CLK),
      .Init_n (Init_n),
      .push   (w_push),
      .pop    (w_pop),
      .clear  (Start),
      .din    (w_pcInc),
      .dout   (w_rasTop),
      .full   (w_full),
      .empty  (w_empty),
      .count  (Depth)
   );

   // Next-PC selection; faulting CALL/RET leave the PC where it is, unused codes fall back to increment.
   always_comb begin
      w_nextPc = w_pcInc;
      case (w_op)
         JUMP:    w_nextPc = Target;
         BRZ:     w_nextPc = ALU_zero ? w_pcRel : w_pcInc;
         BRNZ:    w_nextPc = ALU_zero ? w_pcInc : w_pcRel;
         CALL:    w_nextPc = w_full  ? r_pc : Target;
         RET:     w_nextPc = w_empty ? r_pc : w_rasTop;
         default: w_nextPc = w_pcInc;
      endcase
   end

   // Sequencer state: restart, stall, terminal-state hold, halt detection, then the op itself.
   always_ff @(posedge CLK or negedge Init_n) begin
      if (!Init_n) begin
         r_pc        <= LP_START;
         r_state     <= RUN;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (Start) begin
         r_pc        <= LP_START;
         r_state     <= RUN;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (!Halt && (r_state == RUN)) begin
         if (r_pc == LP_HALT) begin
            r_state <= HALTED;
         end else begin
            r_pc <= w_nextPc;
            if ((w_op == CALL) && w_full) begin
               r_overflow <= 1'b1;
               r_state    <= FAULT;
            end
            if ((w_op == RET) && w_empty) begin
               r_underflow <= 1'b1;
               r_state     <= FAULT;
            end
         end
      end
   end

   assign PC        = r_pc;
   assign Done      = (r_state == HALTED);
   assign Fault     = (r_state == FAULT);
   assign Overflow  = r_overflow;
   assign Underflow = r_underflow;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq with default parameters: a reference model pushes the
// expected post-edge outputs into a scoreboard queue, and a monitor pops and compares them.
module tb_pc_seq;

   logic       CLK;
   logic       Init_n;
   logic       Start;
   logic       Halt;
   logic [2:0] Op;
   logic       ALU_zero;
   logic [9:0] Target;
   logic [9:0] Offset;
   logic [9:0] PC;
   logic       Done;
   logic       Fault;
   logic       Overflow;
   logic       Underflow;
   logic [2:0] Depth;

   typedef struct packed {
      logic [9:0] pc;
      logic [2:0] depth;
      logic       done;
      logic       fault;
      logic       ovf;
      logic       unf;
   } exp_t;

   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   logic [9:0] mPc;
   int         mState;
   logic       mOvf;
   logic       mUnf;
   logic [9:0] mStack[$];

   pc_seq #(
      .PW         (10),
      .DEPTH      (4),
      .START_ADDR (0),
      .HALT_ADDR  (63)
   ) dut (
      .CLK       (CLK),
      .Init_n    (Init_n),
      .Start     (Start),
      .Halt      (Halt),
      .Op        (Op),
      .ALU_zero  (ALU_zero),
      .Target    (Target),
      .Offset    (Offset),
      .PC        (PC),
      .Done      (Done),
      .Fault     (Fault),
      .Overflow  (Overflow),
      .Underflow (Underflow),
      .Depth     (Depth)
   );

   // Free-running clock, 10 time units per cycle.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Single comparison point: counts every check and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reference model reset, shared by Init_n and Start.
   task automatic modelReset();
      mPc    = 10'd0;
      mState = 0;
      mOvf   = 1'b0;
      mUnf   = 1'b0;
      mStack.delete();
   endtask

   // Reference model: one clock edge worth of behaviour.
   task automatic modelStep(input logic start, input logic halt, input logic [2:0] op,
                            input logic zero, input logic [9:0] target, input logic [9:0] offset);
      if (start) begin
         modelReset();
      end else if (halt || mState != 0) begin
         // nothing moves
      end else if (mPc == 10'd63) begin
         mState = 1;
      end else begin
         case (op)
            3'd1: mPc = target;
            3'd2: mPc = zero ? mPc + offset : mPc + 10'd1;
            3'd3: mPc = !zero ? mPc + offset : mPc + 10'd1;
            3'd4: begin
               if (mStack.size() == 4) begin
                  mOvf   = 1'b1;
                  mState = 2;
               end else begin
                  mStack.push_back(mPc + 10'd1);
                  mPc = target;
               end
            end
            3'd5: begin
               if (mStack.size() == 0) begin
                  mUnf   = 1'b1;
                  mState = 2;
               end else begin
                  mPc = mStack.pop_back();
               end
            end
            default: mPc = mPc + 10'd1;
         endcase
      end
   endtask

   // Drive one cycle of stimulus at the falling edge and queue the expected result.
   task automatic applyStimulus(input logic start, input logic halt, input logic [2:0] op,
                                input logic zero, input logic [9:0] target, input logic [9:0] offset);
      exp_t e;
      @(negedge CLK);
      Start    = start;
      Halt     = halt;
      Op       = op;
      ALU_zero = zero;
      Target   = target;
      Offset   = offset;
      modelStep(start, halt, op, zero, target, offset);
      e.pc    = mPc;
      e.depth = 3'(mStack.size());
      e.done  = (mState == 1);
      e.fault = (mState == 2);
      e.ovf   = mOvf;
      e.unf   = mUnf;
      sb.push_back(e);
      @(posedge CLK);
      #2;
   endtask

   task automatic doOp(input logic [2:0] op, input logic zero, input logic [9:0] target,
                       input logic [9:0] offset);
      applyStimulus(1'b0, 1'b0, op, zero, target, offset);
   endtask

   // Monitor: just after each rising edge, compare DUT outputs with the oldest expectation.
   always @(posedge CLK) begin : monitor
      exp_t e;
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checkOutput("pc",        32'(PC),        32'(e.pc));
         checkOutput("depth",     32'(Depth),     32'(e.depth));
         checkOutput("done",      32'(Done),      32'(e.done));
         checkOutput("fault",     32'(Fault),     32'(e.fault));
         checkOutput("overflow",  32'(Overflow),  32'(e.ovf));
         checkOutput("underflow", 32'(Underflow), 32'(e.unf));
      end
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      Init_n   = 1'b0;
      Start    = 1'b0;
      Halt     = 1'b1;
      Op       = 3'd0;
      ALU_zero = 1'b0;
      Target   = 10'd0;
      Offset   = 10'd0;
      modelReset();

      #3;
      checkOutput("rst_pc",    32'(PC),       32'd0);
      checkOutput("rst_depth", 32'(Depth),    32'd0);
      checkOutput("rst_done",  32'(Done),     32'd0);
      checkOutput("rst_fault", 32'(Fault),    32'd0);
      checkOutput("rst_ovf",   32'(Overflow), 32'd0);
      @(negedge CLK);
      Init_n = 1'b1;

      $display("[TB] sequential increment");
      for (int i = 0; i < 5; i++) doOp(3'd0, 1'b0, 10'd0, 10'd0);
      checkOutput("inc5_pc", 32'(PC), 32'd5);

      $display("[TB] branches and wrap");
      doOp(3'd1, 1'b0, 10'd10, 10'd0);
      doOp(3'd2, 1'b1, 10'd0, 10'h3FC);
      checkOutput("brz_taken", 32'(PC), 32'd6);
      doOp(3'd3, 1'b1, 10'd0, 10'd3);
      checkOutput("brnz_not_taken", 32'(PC), 32'd7);
      doOp(3'd2, 1'b0, 10'd0, 10'd100);
      doOp(3'd3, 1'b0, 10'd0, 10'd5);
      checkOutput("brnz_taken", 32'(PC), 32'd13);
      doOp(3'd1, 1'b0, 10'd5, 10'd0);
      doOp(3'd2, 1'b1, 10'd0, 10'h3F8);
      checkOutput("neg_wrap", 32'(PC), 32'd1021);
      doOp(3'd1, 1'b0, 10'd1023, 10'd0);
      doOp(3'd0, 1'b0, 10'd0, 10'd0);
      checkOutput("inc_wrap", 32'(PC), 32'd0);
      doOp(3'd6, 1'b1, 10'd50, 10'd9);
      doOp(3'd7, 1'b1, 10'd50, 10'd9);
      checkOutput("unused_ops", 32'(PC), 32'd2);

      $display("[TB] call and return");
      doOp(3'd1, 1'b0, 10'd3, 10'd0);
      doOp(3'd4, 1'b0, 10'd20, 10'd0);
      checkOutput("call1_pc", 32'(PC), 32'd20);
      doOp(3'd0, 1'b0, 10'd0, 10'd0);
      doOp(3'd4, 1'b0, 10'd30, 10'd0);
      checkOutput("call2_depth", 32'(Depth), 32'd2);
      doOp(3'd5, 1'b0, 10'd0, 10'd0);
      checkOutput("ret1_pc", 32'(PC), 32'd22);
      doOp(3'd5, 1'b0, 10'd0, 10'd0);
      checkOutput("ret2_pc", 32'(PC), 32'd4);

      $display("[TB] stack overflow");
      doOp(3'd1, 1'b0, 10'd0, 10'd0);
      for (int i = 1; i <= 5; i++) doOp(3'd4, 1'b0, 10'(i * 10), 10'd0);
      checkOutput("ovf_pc",    32'(PC),       32'd40);
      checkOutput("ovf_flag",  32'(Overflow), 32'd1);
      checkOutput("ovf_fault", 32'(Fault),    32'd1);
      doOp(3'd0, 1'b0, 10'd0, 10'd0);
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 10'd0, 10'd0);
      checkOutput("start_pc",    32'(PC),       32'd0);
      checkOutput("start_ovf",   32'(Overflow), 32'd0);
      checkOutput("start_depth", 32'(Depth),    32'd0);

      $display("[TB] stall and restart priority");
      doOp(3'd0, 1'b0, 10'd0, 10'd0);
      doOp(3'd0, 1'b0, 10'd0, 10'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 10'd99, 10'd0);
      checkOutput("halt_hold", 32'(PC), 32'd2);
      doOp(3'd0, 1'b0, 10'd0, 10'd0);
      checkOutput("halt_resume", 32'(PC), 32'd3);
      applyStimulus(1'b1, 1'b1, 3'd0, 1'b0, 10'd0, 10'd0);
      checkOutput("start_over_halt", 32'(PC), 32'd0);

      $display("[TB] end of program");
      doOp(3'd1, 1'b0, 10'd62, 10'd0);
      doOp(3'd0, 1'b0, 10'd0, 10'd0);
      checkOutput("at_halt_pc",   32'(PC),   32'd63);
      checkOutput("at_halt_done", 32'(Done), 32'd0);
      doOp(3'd1, 1'b0, 10'd5, 10'd0);
      checkOutput("halted_done", 32'(Done), 32'd1);
      doOp(3'd4, 1'b0, 10'd7, 10'd0);
      checkOutput("halted_pc", 32'(PC), 32'd63);
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 10'd0, 10'd0);

      $display("[TB] asynchronous reset mid call sequence");
      doOp(3'd4, 1'b0, 10'd100, 10'd0);
      doOp(3'd4, 1'b0, 10'd200, 10'd0);
      checkOutput("pre_rst_depth", 32'(Depth), 32'd2);
      #1;
      Halt   = 1'b1;
      Init_n = 1'b0;
      #1;
      checkOutput("async_pc",    32'(PC),    32'd0);
      checkOutput("async_depth", 32'(Depth), 32'd0);
      modelReset();
      @(negedge CLK);
      Init_n = 1'b1;
      doOp(3'd5, 1'b0, 10'd0, 10'd0);
      checkOutput("unf_flag",  32'(Underflow), 32'd1);
      checkOutput("unf_fault", 32'(Fault),     32'd1);
      checkOutput("unf_pc",    32'(PC),        32'd0);

      @(negedge CLK);
      checkOutput("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
